// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access sequencer.
// Holds the pipeline until the memory acks or the wait times out.
module dmem_access_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stall_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] cnt;
  logic          access;
  logic          aligned;
  logic          tmo;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);
  assign tmo     = (cnt == TW'(TIMEOUT - 1));

  assign mem_req_o = (state == REQ);

  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE: stall_o = access & aligned;
      REQ:  stall_o = 1'b1;
      WAIT: stall_o = 1'b1;
      DONE: stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
    // reset must hide the combinational launch stall
    stall_o = stall_o & rst_i;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (access && aligned) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_ack_i || tmo) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_addr_o  <= addr_i;
              mem_wdata_o <= wdata_i;
              mem_we_o    <= MemWrite_i;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= '0;
        end
        WAIT: begin
          // an ack landing on the timeout cycle still completes cleanly
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              rdata_o <= mem_rdata_i;
            end
          end else begin
            cnt <= cnt + TW'(1);
            if (tmo) begin
              err_o <= 1'b1;
              if (!mem_we_o) begin
                rdata_o <= '0;
              end
            end
          end
        end
        DONE: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table plus scoreboard for the
// data-memory access sequencer, with hand-written corner sequences.
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req;
  logic        we;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] rdata;
  logic        err;

  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;

  assign mem_ack   = resp_ack | man_ack;
  assign mem_rdata = man_ack ? man_rdata : resp_rdata;

  dmem_access_ctrl #(
    .AW(32), .DW(32), .TIMEOUT(TMO), .TW(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .MemRead_i  (rd),
    .MemWrite_i (wr),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mem_req_o  (req),
    .mem_we_o   (we),
    .mem_addr_o (maddr),
    .mem_wdata_o(mwdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .stall_o    (stall),
    .rdata_o    (rdata),
    .err_o      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;
    logic [31:0] rdata;
    bit          b2b;
  } vec_t;

  typedef struct {
    bit          mis;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model    = '0;
  int          cur_k    = 0;
  logic [31:0] cur_rd   = '0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // memory model: acks cur_k cycles after it sees a request
  int cd = 0;
  logic [31:0] pend = '0;
  initial begin
    resp_ack   = 1'b0;
    resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (req && cur_k > 0) begin
        cd   = cur_k;
        pend = cur_rd;
      end
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          resp_ack   = 1'b1;
          resp_rdata = pend;
        end
      end
    end
  end

  // monitor: measures each transaction and pops its expectation
  bit          in_txn  = 0;
  int          req_len = 0;
  int          scnt    = 0;
  logic        cwe;
  logic [31:0] caddr;
  logic [31:0] cwd;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_txn = 0;
    end else begin
      if (req) begin
        if (in_txn) begin
          req_len++;
        end else begin
          in_txn  = 1;
          req_len = 1;
          scnt    = 0;
          cwe     = we;
          caddr   = maddr;
          cwd     = mwdata;
        end
      end
      if (in_txn) begin
        if (stall) begin
          scnt++;
        end else begin
          in_txn = 0;
          if (sb.size() == 0) begin
            chk("unexpected_done", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("req_issued", 1, {31'b0, !e.mis});
            chk("req_len", req_len, 1);
            chk("we", cwe, e.we);
            chk("addr", caddr, e.addr);
            chk("wdata", cwd, e.wdata);
            chk("stall_cycles", scnt, e.stall);
            chk("err", err, e.err);
            chk("rdata", rdata, e.rdata);
          end
        end
      end else if (err) begin
        if (sb.size() == 0) begin
          chk("unexpected_err", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("misaligned_err", {31'b0, e.mis}, 1);
        end
      end
    end
  end

  task automatic clear_in();
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   mis;
    bit   ok;
    int   n;
    mis = (v.addr[1:0] != 2'b00);
    @(posedge clk);
    #1;
    cur_k  = v.k;
    cur_rd = v.rdata;
    rd     = v.rd;
    wr     = v.wr;
    addr   = v.addr;
    wdata  = v.wdata;
    e.mis   = mis;
    e.we    = v.wr;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    if (mis) begin
      e.err   = 1'b1;
      e.stall = 0;
    end else begin
      ok = (v.k >= 1 && v.k <= TMO);
      if (v.rd && !v.wr) model = ok ? v.rdata : 32'h0;
      e.err   = !ok;
      e.stall = ok ? v.k + 1 : TMO + 1;
    end
    e.rdata = model;
    sb.push_back(e);
    @(negedge clk);
    chk("launch_stall", {31'b0, stall}, {31'b0, !mis});
    chk("launch_no_req", {31'b0, req}, 0);
    if (mis) begin
      @(posedge clk);
      #1;
      clear_in();
      @(negedge clk);
      @(negedge clk);
      chk("err_pulse_end", {31'b0, err}, 0);
    end else begin
      @(negedge clk);
      chk("req_next_cycle", {31'b0, req}, 1);
      n = 0;
      while (stall && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (stall) chk("done_reached", {31'b0, stall}, 0);
      if (!v.b2b) begin
        @(posedge clk);
        #1;
        clear_in();
      end
    end
  endtask

  vec_t tbl[11];
  vec_t vx;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h10, 32'h0,    3, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h20, 32'h1234, 1, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h13, 32'h0,    2, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h22, 32'h77,   2, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h30, 32'h0,    0, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h34, 32'h0,    1, 32'hCAFEF00D, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h38, 32'h0,    2, 32'h0BADF00D, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 32'h44, 32'h55AA, 2, 32'h99999999, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h48, 32'h0,    4, 32'h11112222, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h4C, 32'h0,    5, 32'h33334444, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h50, 32'h0,    2, 32'h600DCAFE, 1'b0};

    man_ack   = 1'b0;
    man_rdata = '0;
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd   = 1'b1;
    addr = 32'h100;
    #1;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", mwdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {31'b0, err}, 0);
    clear_in();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i]);
    end
    repeat (3) @(negedge clk);

    // asynchronous reset while waiting; the late ack must be ignored
    @(posedge clk);
    #1;
    cur_k  = 10;
    cur_rd = 32'hFEEDFACE;
    rd     = 1'b1;
    addr   = 32'h60;
    repeat (3) @(negedge clk);
    chk("wait_stall", {31'b0, stall}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_stall", {31'b0, stall}, 0);
    chk("async_req", {31'b0, req}, 0);
    chk("async_we", {31'b0, we}, 0);
    chk("async_addr", maddr, 0);
    chk("async_rdata", rdata, 0);
    chk("async_err", {31'b0, err}, 0);
    clear_in();
    model = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_err", {31'b0, err}, 0);
    end
    chk("post_rst_rdata", rdata, model);
    chk("post_rst_req", {31'b0, req}, 0);

    // stray ack while idle
    @(posedge clk);
    #1;
    man_ack   = 1'b1;
    man_rdata = 32'hABCDABCD;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rdata", rdata, model);
    chk("idle_ack_err", {31'b0, err}, 0);
    chk("idle_ack_req", {31'b0, req}, 0);

    // stray ack during the request cycle
    vx = '{1'b1, 1'b0, 32'h70, 32'h0, 2, 32'h12345678, 1'b0};
    fork
      run_vec(vx);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        man_ack   = 1'b1;
        man_rdata = 32'hBADBAD00;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
      end
    join

    vx = '{1'b1, 1'b0, 32'h74, 32'h0, 1, 32'h0F0F0F0F, 1'b0};
    run_vec(vx);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
